// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: pixel/line counters, blank, active-low syncs, frame strobe and counter.
// Define VGA_SYNC_DELAY_EN to delay hs/vs by two pixel clocks to line up with the mapper RGB pipeline.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic [15:0] fc_q, fc_d;
  logic        blank_q, hs_q, vs_q, fs_q;
  logic        h_wrap, v_wrap;

  always_comb begin
    h_wrap = (hc_q == H_LAST);
    v_wrap = (vc_q == V_LAST);
    hc_d   = h_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d   = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
    end
    fc_d = (h_wrap && v_wrap) ? fc_q + 16'd1 : fc_q;
  end

  // Stage p0: counters plus flags decoded from the next counter values, so all stay aligned.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q    <= 10'd0;
      vc_q    <= 10'd0;
      fc_q    <= 16'd0;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      fc_q    <= fc_d;
      blank_q <= (hc_d < H_VIS) && (vc_d < V_VIS);
      hs_q    <= !((hc_d >= HS_FIRST) && (hc_d <= HS_LAST));
      vs_q    <= !((vc_d >= VS_FIRST) && (vc_d <= VS_LAST));
      fs_q    <= (hc_d == 10'd0) && (vc_d == 10'd0);
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_p1_q, hs_p2_q, vs_p1_q, vs_p2_q;

  // Stages p1/p2: sync delay matching the mapper ROM read and RGB register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_p1_q <= 1'b1;
      hs_p2_q <= 1'b1;
      vs_p1_q <= 1'b1;
      vs_p2_q <= 1'b1;
    end else begin
      hs_p1_q <= hs_q;
      hs_p2_q <= hs_p1_q;
      vs_p1_q <= vs_q;
      vs_p2_q <= vs_p1_q;
    end
  end

  assign hs = hs_p2_q;
  assign vs = vs_p2_q;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; horizontal timing at defaults, vertical shrunk to keep frames short.
module tb_vga_timing_gen;

  localparam int VV = 20, VF = 2, VSY = 2, VB = 3;
  localparam int VT = VV + VF + VSY + VB;   // 27 lines
  localparam int HT = 800;
  localparam int FRAME = HT * VT;           // 21600 clocks
`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, hs, vs, frame_start;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;

  vga_timing_gen #(
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .vga_clk    (clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .hs         (hs),
    .vs         (vs),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_x"},     int'(DrawX), 0);
    check({pfx, "_y"},     int'(DrawY), 0);
    check({pfx, "_blank"}, int'(blank), 0);
    check({pfx, "_hs"},    int'(hs), 1);
    check({pfx, "_vs"},    int'(vs), 1);
    check({pfx, "_fs"},    int'(frame_start), 0);
    check({pfx, "_fc"},    int'(frame_count), 0);
  endtask

  initial begin
    int ex, ey, efc;
    int e_hs, e_vs;
    int hs_d1, hs_d2, vs_d1, vs_d2;
    int pos_err, blank_err, hs_err, vs_err, fs_err, fc_err;
    int prev_hs, prev_vs, prev_x, prev_y;
    int hs_fall_x, hs_fall_y, hs_fall_cyc, hs_period, hs_width;
    int vs_fall_x, vs_fall_y, vs_low_total;
    int fs_n, fs_c1, fs_spacing;
    bit post_wrap, found;

    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_vals("reset");

    reset_n = 1'b1;
    ex = 0; ey = 0; efc = 0;
    hs_d1 = 1; hs_d2 = 1; vs_d1 = 1; vs_d2 = 1;
    pos_err = 0; blank_err = 0; hs_err = 0; vs_err = 0; fs_err = 0; fc_err = 0;
    prev_hs = 1; prev_vs = 1; prev_x = 0; prev_y = 0;
    hs_fall_x = -1; hs_fall_y = -1; hs_fall_cyc = -1; hs_period = -1; hs_width = -1;
    vs_fall_x = -1; vs_fall_y = -1; vs_low_total = 0;
    fs_n = 0; fs_c1 = -1; fs_spacing = -1;
    post_wrap = 1'b0;

    for (int cyc = 1; cyc <= 2 * FRAME + 10; cyc++) begin
      @(negedge clk);
      ex++;
      if (ex == HT) begin
        ex = 0;
        ey++;
        if (ey == VT) begin
          ey = 0;
          efc++;
        end
      end
      e_hs = (ex >= 656 && ex <= 751) ? 0 : 1;
      e_vs = (ey >= VV + VF && ey <= VV + VF + VSY - 1) ? 0 : 1;
      if (DLY != 0) begin
        int t_hs, t_vs;
        t_hs = e_hs; t_vs = e_vs;
        e_hs = hs_d2; hs_d2 = hs_d1; hs_d1 = t_hs;
        e_vs = vs_d2; vs_d2 = vs_d1; vs_d1 = t_vs;
      end

      if (cyc == 1) begin
        check("first_x", int'(DrawX), 1);
        check("first_y", int'(DrawY), 0);
        check("first_blank", int'(blank), 1);
        check("first_fs", int'(frame_start), 0);
      end

      if (int'(DrawX) != ex || int'(DrawY) != ey) pos_err++;
      if (int'(blank) != ((ex < 640 && ey < VV) ? 1 : 0)) blank_err++;
      if (int'(hs) != e_hs) hs_err++;
      if (int'(vs) != e_vs) vs_err++;
      if (int'(frame_start) != ((ex == 0 && ey == 0) ? 1 : 0)) fs_err++;
      if (int'(frame_count) != efc) fc_err++;

      if (prev_hs == 1 && hs == 1'b0) begin
        if (hs_fall_x < 0) begin
          hs_fall_x = int'(DrawX); hs_fall_y = int'(DrawY); hs_fall_cyc = cyc;
        end else if (hs_period < 0) begin
          hs_period = cyc - hs_fall_cyc;
        end
      end
      if (prev_hs == 0 && hs == 1'b1 && hs_width < 0 && hs_fall_cyc >= 0)
        hs_width = cyc - hs_fall_cyc;
      if (prev_vs == 1 && vs == 1'b0 && vs_fall_x < 0) begin
        vs_fall_x = int'(DrawX); vs_fall_y = int'(DrawY);
      end
      if (vs == 1'b0) vs_low_total++;

      if (frame_start) begin
        fs_n++;
        check("fs_pos_x", int'(DrawX), 0);
        check("fs_pos_y", int'(DrawY), 0);
        check("fs_count", int'(frame_count), fs_n);
        if (fs_n == 1) fs_c1 = cyc;
        else if (fs_n == 2) fs_spacing = cyc - fs_c1;
      end

      if (prev_x == 799 && prev_y == VT - 1) begin
        check("wrap_x", int'(DrawX), 0);
        check("wrap_y", int'(DrawY), 0);
        check("wrap_fs", int'(frame_start), 1);
        check("wrap_blank", int'(blank), 1);
        post_wrap = 1'b1;
      end else if (post_wrap) begin
        check("post_wrap_fs", int'(frame_start), 0);
        post_wrap = 1'b0;
      end

      prev_hs = int'(hs); prev_vs = int'(vs);
      prev_x = int'(DrawX); prev_y = int'(DrawY);
    end

    check("pos_errs", pos_err, 0);
    check("blank_errs", blank_err, 0);
    check("hs_errs", hs_err, 0);
    check("vs_errs", vs_err, 0);
    check("fs_errs", fs_err, 0);
    check("fc_errs", fc_err, 0);
    check("hs_first_low_x", hs_fall_x, 656 + DLY);
    check("hs_first_low_y", hs_fall_y, 0);
    check("hs_width", hs_width, 96);
    check("hs_period", hs_period, HT);
    check("vs_first_low_x", vs_fall_x, DLY);
    check("vs_first_low_y", vs_fall_y, VV + VF);
    check("vs_low_total", vs_low_total, 2 * VSY * HT);
    check("fs_pulses", fs_n, 2);
    check("fs_spacing", fs_spacing, FRAME);
    check("frame_count_end", int'(frame_count), 2);

    // Mid-frame reset at (300,10)
    found = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) begin
      @(negedge clk);
      if (DrawX == 10'd300 && DrawY == 10'd10) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_found", int'(found), 1);
    #5 reset_n = 1'b0;
    #1 check_reset_vals("midrst_async");
    repeat (3) @(negedge clk);
    check_reset_vals("midrst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_rel_x", int'(DrawX), 1);
    check("midrst_rel_y", int'(DrawY), 0);
    check("midrst_rel_blank", int'(blank), 1);
    check("midrst_rel_fc", int'(frame_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
